// File: rtl/serial_tx_unit_pkg.sv
// Shared definitions for the serial transmit path: FSM encodings and default bit timing.
package serial_tx_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DEFAULT_DATA_W       = 8;

endpackage

// File: rtl/serial_tx_unit_fifo.sv
// Synchronous show-ahead byte FIFO; a push into a full FIFO is ignored even when a pop happens on the same edge.
module serial_tx_fifo
    import serial_tx_unit_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_data,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_wr = i_push & ~o_full;
    assign w_rd = i_pop  & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_unit.sv
// 8N1 LSB-first serial transmitter fed by a small byte FIFO so OUT instructions never stall the core.
module serial_tx_unit
    import serial_tx_unit_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W       = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_out_en,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              overflow_clr,
    output logic              serial_tx,
    output logic              tx_busy,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [CNT_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_overflow;
    logic               w_pop;
    logic               w_baud_end;
    logic               w_drop;

    logic [DATA_W-1:0]  w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FCNT_W-1:0]  w_fifo_count;

    serial_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (serial_out_en),
        .i_pop   (w_pop),
        .i_data  (acc_data),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_end = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_drop     = serial_out_en & w_fifo_full;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_end ? '0 : r_baud_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == BIT_W'(DATA_W - 1)) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next frame when more bytes are waiting.
                if (w_baud_end) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The line level is decided from the next state so it changes on the same edge as the FSM.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // A dropped push outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign serial_tx = r_tx;
    assign tx_busy   = (r_state != ST_IDLE) | (w_fifo_count != '0);
    assign fifo_full = w_fifo_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_tx_unit.sv
// Scoreboard bench for serial_tx_unit: a line receiver pops expected bytes, scenario tasks check timing and flags.
module tb_serial_tx_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_out_en = 1'b0;
    logic [7:0] acc_data = 8'h00;
    logic       overflow_clr = 1'b0;
    logic       serial_tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];

    logic       mon_en = 1'b1;
    logic       mon_busy = 1'b0;
    logic       mon_abort;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;

    serial_tx_unit #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .DATA_W       (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_out_en (serial_out_en),
        .acc_data      (acc_data),
        .overflow_clr  (overflow_clr),
        .serial_tx     (serial_tx),
        .tx_busy       (tx_busy),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Line receiver: samples one negedge into each 4-clock bit.
    always begin
        @(negedge clk);
        if (mon_en && reset_n && serial_tx === 1'b0) begin
            mon_busy  = 1'b1;
            mon_abort = 1'b0;
            mon_rx    = 8'h00;
            for (int k = 0; k < 10 && !mon_abort; k++) begin
                for (int w = 0; w < ((k == 0) ? 1 : 4); w++) begin
                    @(negedge clk);
                    if (!reset_n) mon_abort = 1'b1;
                end
                if (!mon_abort) begin
                    if (k >= 1 && k <= 8) begin
                        mon_rx[k-1] = serial_tx;
                    end else begin
                        vectors++;
                        if (serial_tx !== ((k == 9) ? 1'b1 : 1'b0)) begin
                            miscompares++;
                            $display("FAIL rx_framing bit%0d: got %b required %b", k, serial_tx, (k == 9));
                        end
                    end
                end
            end
            if (!mon_abort) begin
                repeat (2) @(negedge clk);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_unexpected: got byte %02h required none", mon_rx);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_rx !== mon_exp) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %02h required %02h", mon_rx, mon_exp);
                    end
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (serial_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b required 1", serial_tx); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
        vectors++; if (fifo_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b required 0", fifo_full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b required 0", overflow); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (serial_tx !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle: got tx=%b busy=%b required tx=1 busy=0", serial_tx, tx_busy);
        end
    endtask

    task automatic test_single;
        logic [7:0] b;
        b = 8'hA5;
        @(negedge clk); serial_out_en = 1'b1; acc_data = b; exp_q.push_back(b);
        @(negedge clk); serial_out_en = 1'b0;
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_after_push: got %b required 1", tx_busy); end
        vectors++; if (serial_tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_before_pop: got %b required 1", serial_tx); end
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            vectors++;
            if (serial_tx !== frame_bit(b, (j-1)/4)) begin
                miscompares++; $display("FAIL single_wave clk%0d: got %b required %b", j, serial_tx, frame_bit(b, (j-1)/4));
            end
            vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy clk%0d: got %b required 1", j, tx_busy); end
        end
        @(negedge clk);
        vectors++; if (tx_busy !== 1'b0 || serial_tx !== 1'b1) begin
            miscompares++; $display("FAIL single_end: got busy=%b tx=%b required busy=0 tx=1", tx_busy, serial_tx);
        end
    endtask

    task automatic test_patterns;
        logic [7:0] pats [2];
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); serial_out_en = 1'b1; acc_data = pats[p]; exp_q.push_back(pats[p]);
            @(negedge clk); serial_out_en = 1'b0;
            for (int j = 1; j <= 40; j++) begin
                @(negedge clk);
                vectors++;
                if (serial_tx !== frame_bit(pats[p], (j-1)/4)) begin
                    miscompares++; $display("FAIL pattern_%02h clk%0d: got %b required %b", pats[p], j, serial_tx, frame_bit(pats[p], (j-1)/4));
                end
            end
            @(negedge clk);
            vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL pattern_%02h_end_busy: got %b required 0", pats[p], tx_busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] eb;
        @(negedge clk); serial_out_en = 1'b1; acc_data = 8'h01; exp_q.push_back(8'h01);
        for (int j = 0; j <= 200; j++) begin
            @(negedge clk);
            if (j >= 1) begin
                eb = 8'((j-1)/40 + 1);
                vectors++;
                if (serial_tx !== frame_bit(eb, ((j-1)%40)/4)) begin
                    miscompares++; $display("FAIL b2b_wave clk%0d: got %b required %b", j, serial_tx, frame_bit(eb, ((j-1)%40)/4));
                end
            end
            vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy clk%0d: got %b required 1", j, tx_busy); end
            if (j == 3) begin
                vectors++; if (fifo_full !== 1'b0 || overflow !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_pre_full: got full=%b ovf=%b required 0 0", fifo_full, overflow);
                end
            end
            if (j == 4) begin
                vectors++; if (fifo_full !== 1'b1) begin miscompares++; $display("FAIL b2b_full: got %b required 1", fifo_full); end
            end
            if (j == 5) begin
                vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL b2b_overflow: got %b required 1", overflow); end
            end
            if (j < 4) begin
                acc_data = 8'(j + 2); exp_q.push_back(8'(j + 2));
            end else if (j == 4) begin
                acc_data = 8'h06;
            end else begin
                serial_out_en = 1'b0;
            end
        end
        @(negedge clk);
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy: got %b required 0", tx_busy); end
    endtask

    task automatic test_overflow;
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear1: got %b required 0", overflow); end
        @(negedge clk); serial_out_en = 1'b1; acc_data = 8'h10; exp_q.push_back(8'h10);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            if (j < 4) begin
                acc_data = 8'(8'h11 + j); exp_q.push_back(8'(8'h11 + j));
            end else if (j == 4) begin
                acc_data = 8'h15; overflow_clr = 1'b1;
            end else begin
                serial_out_en = 1'b0; overflow_clr = 1'b0;
                vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b required 1", overflow); end
            end
        end
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear2: got %b required 0", overflow); end
        for (int i = 0; i < 1000 && tx_busy; i++) @(negedge clk);
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL ovf_drain_timeout: got busy=%b required 0", tx_busy); end
    endtask

    task automatic test_reset_midframe;
        mon_en = 1'b0;
        @(negedge clk); serial_out_en = 1'b1; acc_data = 8'h3C;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            if (j == 0) acc_data = 8'h11;
            if (j == 1) acc_data = 8'h22;
            if (j == 2) serial_out_en = 1'b0;
        end
        vectors++; if (serial_tx !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pre: got %b required 0", serial_tx); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (serial_tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b required 1", serial_tx); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b required 0", tx_busy); end
        vectors++; if (fifo_full !== 1'b0) begin miscompares++; $display("FAIL rst_mid_full: got %b required 0", fifo_full); end
        @(negedge clk); reset_n = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            vectors++;
            if (serial_tx !== 1'b1 || tx_busy !== 1'b0) begin
                miscompares++; $display("FAIL rst_mid_quiet clk%0d: got tx=%b busy=%b required tx=1 busy=0", j, serial_tx, tx_busy);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_push_on_pop;
        @(negedge clk); serial_out_en = 1'b1; acc_data = 8'h5A; exp_q.push_back(8'h5A);
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            case (j)
                0: begin acc_data = 8'h69; exp_q.push_back(8'h69); end
                1: begin acc_data = 8'h78; exp_q.push_back(8'h78); end
                2: begin acc_data = 8'h87; exp_q.push_back(8'h87); end
                3: begin
                    serial_out_en = 1'b0;
                    vectors++; if (fifo_full !== 1'b0) begin miscompares++; $display("FAIL pop_push_q3_full: got %b required 0", fifo_full); end
                end
                40: begin serial_out_en = 1'b1; acc_data = 8'h96; exp_q.push_back(8'h96); end
                41: begin
                    serial_out_en = 1'b0;
                    vectors++; if (fifo_full !== 1'b0) begin miscompares++; $display("FAIL pop_push_count: got full=%b required 0", fifo_full); end
                    vectors++; if (serial_tx !== 1'b0) begin miscompares++; $display("FAIL pop_push_no_gap: got %b required 0", serial_tx); end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < 1000 && tx_busy; i++) @(negedge clk);
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL pop_push_drain_timeout: got busy=%b required 0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_push_on_pop();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_left: got %0d bytes outstanding required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
